seq_det_ctrl: RTL and testbench

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

---
 rtl/seq_det_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_det_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_ctrl.sv
// Serializes DATA_W-bit words MSB first and flags a configurable 2..8 bit pattern (Mealy match).
// Each word takes DATA_W+2 cycles. s_ready is high only in IDLE. abort cancels the word in flight.
module seq_det_ctrl #(
    parameter int DATA_W = 16,
    parameter int CW     = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_load,
    input  logic [7:0]        cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    output logic              err_cfg,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              abort,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              match,
    output logic              done,
    output logic [CW-1:0]     match_cnt
);

    localparam int BW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] data_q;
    logic [BW-1:0]     bit_cnt_q;
    logic [6:0]        hist_q, hist_d;
    logic [2:0]        fill_q, fill_d;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        pat_q;
    logic [3:0]        len_q;
    logic              ovl_q;
    logic              err_q;

    logic       xfer;
    logic       cfg_ok;
    logic       last_bit;
    logic       enough;
    logic [7:0] window;
    logic [7:0] mask;

    assign s_ready   = (state_q == IDLE);
    assign ser_valid = (state_q == SHIFT);
    assign ser_bit   = ser_valid & data_q[DATA_W-1];
    assign done      = (state_q == DONE);
    assign err_cfg   = err_q;
    assign match_cnt = cnt_q;

    assign xfer     = s_valid && s_ready;
    assign cfg_ok   = (cfg_len >= 4'd2) && (cfg_len <= 4'd8);
    assign last_bit = (bit_cnt_q == BW'(DATA_W - 1));

    // fill_q counts history bits gathered since word start or the last
    // non-overlapping match; the current bit makes up the rest of the window.
    assign window = {hist_q, ser_bit};
    assign mask   = 8'hFF >> (4'd8 - len_q);
    assign enough = ({1'b0, fill_q} + 4'd1) >= len_q;
    assign match  = ser_valid && enough && (((window ^ pat_q) & mask) == 8'h00);

    always_comb begin
        hist_d = window[6:0];
        fill_d = (fill_q == 3'd7) ? 3'd7 : fill_q + 3'd1;
        if (match && !ovl_q) begin
            hist_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            data_q    <= '0;
            bit_cnt_q <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            pat_q     <= 8'h0A;
            len_q     <= 4'd4;
            ovl_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            err_q <= cfg_load && ((state_q != IDLE) || !cfg_ok);
            case (state_q)
                IDLE: begin
                    // A legal config written alongside a transfer governs that word.
                    if (cfg_load && cfg_ok) begin
                        pat_q <= cfg_pattern;
                        len_q <= cfg_len;
                        ovl_q <= cfg_overlap;
                    end
                    if (xfer) begin
                        data_q    <= s_data;
                        bit_cnt_q <= '0;
                        hist_q    <= '0;
                        fill_q    <= '0;
                        cnt_q     <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q    <= data_q << 1;
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                    hist_q    <= hist_d;
                    fill_q    <= fill_d;
                    if (match) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (last_bit) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl at DATA_W=16 with hand-computed match positions and counts.
module tb_seq_det_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_load;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        err_cfg;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        abort;
    logic        ser_bit;
    logic        ser_valid;
    logic        match;
    logic        done;
    logic [4:0]  match_cnt;

    int errors = 0;
    int checks = 0;

    seq_det_ctrl #(.DATA_W(16)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .err_cfg(err_cfg),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .abort(abort), .ser_bit(ser_bit), .ser_valid(ser_valid),
        .match(match), .done(done), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mmask;
        logic [15:0] bits;
        int          nvalid;
        int          ndone;
        int          nerr;
        int          nleak;
        int          nrdy;
        logic [4:0]  cnt_end;
        logic        rdy_end;
    } obs_t;

    // Sends one word and records what the DUT did; the calling test judges it.
    // mmask bit k-1 is set when match fired on serial bit k.
    task automatic send_word(input logic [15:0] d, input int abort_at, input int mid_ld_at,
                             input logic ld, input logic [7:0] pat, input logic [3:0] len,
                             input logic ovl, output obs_t o);
        o.mmask = '0; o.bits = '0; o.nvalid = 0; o.ndone = 0; o.nerr = 0;
        o.nleak = 0; o.nrdy = 0; o.cnt_end = '0; o.rdy_end = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = d;
        cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
        @(posedge clk); #1;
        s_valid = 1'b0; cfg_load = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == abort_at) abort = 1'b1;
            if (k == mid_ld_at) begin
                cfg_load = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd3; cfg_overlap = 1'b1;
            end
            @(negedge clk);
            if (ser_valid) o.nvalid++;
            if (match) o.mmask[k-1] = 1'b1;
            o.bits[16-k] = ser_bit;
            if (err_cfg) o.nerr++;
            if (s_ready) o.nrdy++;
            if (done) o.ndone++;
            @(posedge clk); #1;
            abort = 1'b0; cfg_load = 1'b0;
            if (k == abort_at) break;
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            if (done) o.ndone++;
            if (err_cfg) o.nerr++;
            if (ser_valid || ser_bit || match) o.nleak++;
            if (j == 1) begin
                o.cnt_end = match_cnt;
                o.rdy_end = s_ready;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        s_valid = 1'b0; s_data = '0; abort = 1'b0;
        #3;
        checks++;
        if ({ser_bit, ser_valid, match, done, err_cfg, match_cnt} !== 10'd0) begin
            errors++;
            $display("FAIL reset_during: outputs=%b required 0", {ser_bit, ser_valid, match, done, err_cfg, match_cnt});
        end
        #19 rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || {ser_bit, ser_valid, match, done, err_cfg} !== 5'd0 || match_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_after: s_ready=%b outs=%b cnt=%0d required 1/0/0", s_ready,
                     {ser_bit, ser_valid, match, done, err_cfg}, match_cnt);
        end
    endtask

    task automatic test_overlap_default;
        obs_t o;
        send_word(16'hAAAA, 0, 0, 1'b0, 8'h00, 4'd0, 1'b0, o);
        checks++;
        if (o.mmask !== 16'hAAA8) begin errors++; $display("FAIL ovl_mask: got %h required aaa8", o.mmask); end
        checks++;
        if (o.cnt_end !== 5'd7) begin errors++; $display("FAIL ovl_cnt: got %0d required 7", o.cnt_end); end
        checks++;
        if (o.bits !== 16'hAAAA || o.nvalid != 16) begin
            errors++; $display("FAIL ovl_serial: bits=%h valid=%0d required aaaa/16", o.bits, o.nvalid);
        end
        checks++;
        if (o.ndone != 1 || o.nleak != 0 || o.nrdy != 0 || o.rdy_end !== 1'b1) begin
            errors++;
            $display("FAIL ovl_framing: done=%0d leak=%0d rdy_busy=%0d rdy_end=%b required 1/0/0/1",
                     o.ndone, o.nleak, o.nrdy, o.rdy_end);
        end
    endtask

    task automatic test_non_overlap;
        obs_t o;
        send_word(16'hAAAA, 0, 0, 1'b1, 8'h0A, 4'd4, 1'b0, o);
        checks++;
        if (o.mmask !== 16'h8888 || o.cnt_end !== 5'd4) begin
            errors++; $display("FAIL novl: mask=%h cnt=%0d required 8888/4", o.mmask, o.cnt_end);
        end
        checks++;
        if (o.nerr != 0) begin errors++; $display("FAIL novl_err: got %0d required 0", o.nerr); end
    endtask

    task automatic test_len3;
        obs_t o;
        send_word(16'hFFFF, 0, 0, 1'b1, 8'h07, 4'd3, 1'b1, o);
        checks++;
        if (o.mmask !== 16'hFFFC || o.cnt_end !== 5'd14) begin
            errors++; $display("FAIL len3_ones: mask=%h cnt=%0d required fffc/14", o.mmask, o.cnt_end);
        end
        send_word(16'h0000, 0, 0, 1'b0, 8'h00, 4'd0, 1'b0, o);
        checks++;
        if (o.mmask !== 16'h0000 || o.cnt_end !== 5'd0) begin
            errors++; $display("FAIL len3_zeros: mask=%h cnt=%0d required 0000/0", o.mmask, o.cnt_end);
        end
    endtask

    task automatic test_cfg_err;
        obs_t o;
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_pattern = 8'h0A; cfg_len = 4'd4; cfg_overlap = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        @(negedge clk);
        checks++;
        if (err_cfg !== 1'b0) begin errors++; $display("FAIL cfg_legal_err: got %b required 0", err_cfg); end
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd9; cfg_overlap = 1'b0;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        @(negedge clk);
        checks++;
        if (err_cfg !== 1'b1) begin errors++; $display("FAIL cfg_len9_pulse: got %b required 1", err_cfg); end
        @(negedge clk);
        checks++;
        if (err_cfg !== 1'b0) begin errors++; $display("FAIL cfg_len9_width: got %b required 0", err_cfg); end
        send_word(16'hAAAA, 0, 5, 1'b0, 8'h00, 4'd0, 1'b0, o);
        checks++;
        if (o.nerr != 1 || o.cnt_end !== 5'd7) begin
            errors++; $display("FAIL cfg_in_shift: err=%0d cnt=%0d required 1/7", o.nerr, o.cnt_end);
        end
        send_word(16'hAAAA, 0, 0, 1'b1, 8'h07, 4'd1, 1'b1, o);
        checks++;
        if (o.nerr != 1 || o.mmask !== 16'hAAA8 || o.cnt_end !== 5'd7) begin
            errors++;
            $display("FAIL cfg_bad_with_xfer: err=%0d mask=%h cnt=%0d required 1/aaa8/7", o.nerr, o.mmask, o.cnt_end);
        end
    endtask

    task automatic test_abort;
        obs_t o;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        send_word(16'hAAAA, 8, 0, 1'b0, 8'h00, 4'd0, 1'b0, o);
        checks++;
        if (o.mmask !== 16'h00A8 || o.cnt_end !== 5'd3) begin
            errors++; $display("FAIL abort_cnt: mask=%h cnt=%0d required 00a8/3", o.mmask, o.cnt_end);
        end
        checks++;
        if (o.ndone != 0 || o.nvalid != 8 || o.nleak != 0 || o.rdy_end !== 1'b1) begin
            errors++;
            $display("FAIL abort_framing: done=%0d valid=%0d leak=%0d rdy=%b required 0/8/0/1",
                     o.ndone, o.nvalid, o.nleak, o.rdy_end);
        end
        send_word(16'hAAAA, 16, 0, 1'b0, 8'h00, 4'd0, 1'b0, o);
        checks++;
        if (o.ndone != 0 || o.cnt_end !== 5'd7 || o.nvalid != 16) begin
            errors++;
            $display("FAIL abort_last_bit: done=%0d cnt=%0d valid=%0d required 0/7/16", o.ndone, o.cnt_end, o.nvalid);
        end
        send_word(16'hAAAA, 0, 0, 1'b0, 8'h00, 4'd0, 1'b0, o);
        checks++;
        if (o.ndone != 1 || o.cnt_end !== 5'd7) begin
            errors++; $display("FAIL abort_next_word: done=%0d cnt=%0d required 1/7", o.ndone, o.cnt_end);
        end
    endtask

    task automatic test_reset_mid_shift;
        obs_t o;
        @(posedge clk); #1;
        cfg_load = 1'b1; cfg_pattern = 8'h07; cfg_len = 4'd3; cfg_overlap = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        s_valid = 1'b1; s_data = 16'hFFFF;
        @(posedge clk); #1;
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (ser_valid !== 1'b1 || match_cnt !== 5'd1) begin
            errors++; $display("FAIL pre_reset_shift: valid=%b cnt=%0d required 1/1", ser_valid, match_cnt);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({ser_bit, ser_valid, match, done, err_cfg} !== 5'd0 || match_cnt !== 5'd0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_shift: outs=%b cnt=%0d rdy=%b required 0/0/1",
                     {ser_bit, ser_valid, match, done, err_cfg}, match_cnt, s_ready);
        end
        #1 rstn = 1'b1;
        send_word(16'hAAAA, 0, 0, 1'b0, 8'h00, 4'd0, 1'b0, o);
        checks++;
        if (o.mmask !== 16'hAAA8 || o.cnt_end !== 5'd7) begin
            errors++; $display("FAIL reset_cfg_default: mask=%h cnt=%0d required aaa8/7", o.mmask, o.cnt_end);
        end
    endtask

    initial begin
        test_reset();
        test_overlap_default();
        test_non_overlap();
        test_len3();
        test_cfg_err();
        test_abort();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
